// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states and default width.
package div_pkg;

   localparam int W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; no flow control.
module div_step
   import div_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W:0]   rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] dvm_i,
   output logic [W:0]   rem_o,
   output logic         qbit_o
);

   logic [W+1:0] sh;
   logic [W+1:0] diff;

   always_comb begin
      sh     = {rem_i, bit_i};
      diff   = sh - {2'b00, dvm_i};
      // A borrow out of the top bit means the divisor did not fit.
      qbit_o = ~diff[W+1];
      rem_o  = qbit_o ? diff[W:0] : sh[W:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Signed sequential divider (truncating, remainder takes dividend sign), W iterations per op.
// done pulses W+2 edges after acceptance (1 edge for divide-by-zero); start is ignored while busy.
module seq_divider
   import div_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] Dd,
   input  logic [W-1:0] Dv,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         dbz,
   output logic         ovf
);

   localparam int CW = $clog2(W);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W:0]     rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   dvm_q, dvm_d;
   logic           sdd_q, sdd_d;
   logic           sdv_q, sdv_d;
   logic [W-1:0]   resq_q, resq_d;
   logic [W-1:0]   resr_q, resr_d;
   logic           rdbz_q, rdbz_d;
   logic           rovf_q, rovf_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   r_q, r_d;
   logic           dbz_q, dbz_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;

   logic [W:0]     step_rem;
   logic           step_qbit;

   div_step #(.W(W)) u_step (
      .rem_i  (rem_q),
      .bit_i  (quo_q[W-1]),
      .dvm_i  (dvm_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvm_d   = dvm_q;
      sdd_d   = sdd_q;
      sdv_d   = sdv_q;
      resq_d  = resq_q;
      resr_d  = resr_q;
      rdbz_d  = rdbz_q;
      rovf_d  = rovf_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d  = 1'b0;
               ovf_d  = 1'b0;
               sdd_d  = Dd[W-1];
               sdv_d  = Dv[W-1];
               cnt_d  = '0;
               rem_d  = '0;
               rovf_d = 1'b0;
               if (Dv == '0) begin
                  resq_d  = '1;
                  resr_d  = Dd;
                  rdbz_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  // Negating -2^(W-1) wraps to itself, which is exactly its unsigned magnitude.
                  quo_d   = Dd[W-1] ? -Dd : Dd;
                  dvm_d   = Dv[W-1] ? -Dv : Dv;
                  rdbz_d  = 1'b0;
                  state_d = CALC;
               end
            end
         end

         CALC: begin
            rem_d = step_rem;
            quo_d = {quo_q[W-2:0], step_qbit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            resq_d  = (sdd_q ^ sdv_q) ? -quo_q : quo_q;
            resr_d  = sdd_q ? -rem_q[W-1:0] : rem_q[W-1:0];
            // A same-sign magnitude of 2^(W-1) only arises from -2^(W-1) / -1.
            rovf_d  = ~(sdd_q ^ sdv_q) & quo_q[W-1];
            state_d = DONE;
         end

         DONE: begin
            done_d  = 1'b1;
            q_d     = resq_q;
            r_d     = resr_q;
            dbz_d   = rdbz_q;
            ovf_d   = rovf_q;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvm_q   <= '0;
         sdd_q   <= 1'b0;
         sdv_q   <= 1'b0;
         resq_q  <= '0;
         resr_q  <= '0;
         rdbz_q  <= 1'b0;
         rovf_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvm_q   <= dvm_d;
         sdd_q   <= sdd_d;
         sdv_q   <= sdv_d;
         resq_q  <= resq_d;
         resr_q  <= resr_d;
         rdbz_q  <= rdbz_d;
         rovf_q  <= rovf_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign Q    = q_q;
   assign R    = r_q;
   assign dbz  = dbz_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic/timing model checked every cycle plus directed literal results.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] Dd = '0;
   logic [W-1:0] Dv = '0;
   logic         busy, done, dbz, ovf;
   logic [W-1:0] Q, R;

   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;

   seq_divider #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Dd    (Dd),
      .Dv    (Dv),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at time %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result from plain signed arithmetic.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z, output logic o);
      int ia;
      int ib;
      ia = $signed(a);
      ib = $signed(b);
      z = 1'b0;
      o = 1'b0;
      if (ib == 0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (ia == -(1 << (W - 1)) && ib == -1) begin
         q = a;
         r = '0;
         o = 1'b1;
      end else begin
         q = W'(ia / ib);
         r = W'(ia % ib);
      end
   endfunction

   // Timing model: an operation occupies the unit from acceptance until its done edge.
   int           cyc = 0;
   int           m_done_at = 0;
   bit           m_pend = 1'b0;
   bit           was_busy;
   logic [W-1:0] p_q, p_r;
   logic         p_z, p_o;
   logic         e_done = 1'b0, e_busy = 1'b0, e_dbz = 1'b0, e_ovf = 1'b0;
   logic [W-1:0] e_q = '0, e_r = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 1'b0;
         e_done = 1'b0;
         e_busy = 1'b0;
         e_q    = '0;
         e_r    = '0;
         e_dbz  = 1'b0;
         e_ovf  = 1'b0;
      end else begin
         cyc++;
         was_busy = m_pend;
         e_done   = 1'b0;
         if (m_pend && cyc == m_done_at) begin
            e_done = 1'b1;
            e_q    = p_q;
            e_r    = p_r;
            e_dbz  = p_z;
            e_ovf  = p_o;
            m_pend = 1'b0;
         end
         if (!was_busy && start) begin
            ref_div(Dd, Dv, p_q, p_r, p_z, p_o);
            m_pend    = 1'b1;
            m_done_at = cyc + ((Dv == '0) ? 1 : W + 2);
            e_dbz     = 1'b0;
            e_ovf     = 1'b0;
         end
         e_busy = m_pend;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("done", 32'(done), 32'(e_done));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("Q",    32'(Q),    32'(e_q));
         chk("R",    32'(R),    32'(e_r));
         chk("dbz",  32'(dbz),  32'(e_dbz));
         chk("ovf",  32'(ovf),  32'(e_ovf));
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] xq, input logic [W-1:0] xr,
                        input logic xz, input logic xo, input int xlat,
                        input bit poke, input string nm);
      int n;
      @(negedge clk);
      start = 1'b1;
      Dd    = a;
      Dv    = b;
      @(negedge clk);
      start = 1'b0;
      Dd    = W'($urandom);
      Dv    = W'($urandom);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (poke && n == 2) begin
            start = 1'b1;
            Dd    = 4'b0101;
            Dv    = 4'b0001;
         end else begin
            start = 1'b0;
         end
      end
      chk({nm, "_lat"}, 32'(n), 32'(xlat));
      chk({nm, "_Q"},   32'(Q),   32'(xq));
      chk({nm, "_R"},   32'(R),   32'(xr));
      chk({nm, "_dbz"}, 32'(dbz), 32'(xz));
      chk({nm, "_ovf"}, 32'(ovf), 32'(xo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      @(posedge clk);
      #1 armed = 1'b1;
      @(negedge clk);
      chk("rst_Q",    32'(Q),    32'd0);
      chk("rst_R",    32'(R),    32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz",  32'(dbz),  32'd0);
      chk("rst_ovf",  32'(ovf),  32'd0);
      #2 rst = 1'b0;

      do_op(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 6, 1'b0, "p7d2");
      do_op(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 6, 1'b0, "m7d2");
      do_op(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 6, 1'b0, "p7dm2");
      do_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 6, 1'b0, "ovf");
      do_op(4'b1000, 4'b0111, 4'b1111, 4'b1111, 1'b0, 1'b0, 6, 1'b0, "m8d7");
      do_op(4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0, 1, 1'b0, "dbz");
      do_op(4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 6, 1'b0, "dbzclr");
      do_op(4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 6, 1'b0, "m8d1");
      do_op(4'b1111, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 6, 1'b0, "m1dm8");
      do_op(4'b0011, 4'b1000, 4'b0000, 4'b0011, 1'b0, 1'b0, 6, 1'b0, "p3dm8");

      // Start pulsed mid-operation must be ignored; result holds afterwards.
      do_op(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 6, 1'b1, "poke");
      repeat (3) @(negedge clk);
      chk("hold_Q", 32'(Q), 32'd3);
      chk("hold_R", 32'(R), 32'd1);

      // Reset during the third CALC cycle aborts with no done pulse.
      @(negedge clk);
      start = 1'b1;
      Dd    = 4'b0101;
      Dv    = 4'b0011;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("abort_Q",    32'(Q),    32'd0);
      chk("abort_R",    32'(R),    32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done), 32'd0);
      end
      do_op(4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 6, 1'b0, "restart");

      // Start held through done: second op accepted after exactly one idle cycle.
      @(negedge clk);
      start = 1'b1;
      Dd    = 4'b0111;
      Dv    = 4'b0010;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat1", 32'(n), 32'd7);
      chk("b2b_Q1",   32'(Q), 32'd3);
      Dd = 4'b1001;
      Dv = 4'b0010;
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat2", 32'(n), 32'd6);
      chk("b2b_Q2",   32'(Q), 32'(4'b1101));
      chk("b2b_R2",   32'(R), 32'(4'b1111));

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
